signed_divider: RTL and testbench



---
 rtl/signed_divider.sv | 185 ++++++++++++++++++
 tb/tb_signed_divider.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
`default_nettype none
// ============================================================================
//  Module   : signed_divider
//  Purpose  : Iterative restoring signed divider producing quotient (lo) and
//             remainder (hi) with a fixed 33-cycle latency and a done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;

    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_mag;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_divisor_zero;
    logic               w_accept;
    logic               w_zero_req;
    logic               w_step;
    logic               w_finish;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_rem_shifted;
    logic [WIDTH:0]     w_trial;

    assign w_divisor_zero = (divisor == '0);

    // Magnitudes are unsigned, so the most negative value maps onto 2^(WIDTH-1).
    assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;

    assign w_rem_shifted = {r_rem, r_q[WIDTH-1]};
    assign w_trial       = w_rem_shifted - {1'b0, r_mag};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (start && !w_divisor_zero) begin
                    w_next_state = c_calc;
                end
            end
            c_calc: begin
                if (r_count == c_last_step) begin
                    w_next_state = c_fix;
                end
            end
            c_fix: begin
                w_next_state = c_idle;
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        w_accept   = 1'b0;
        w_zero_req = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            c_idle: begin
                w_accept   = start && !w_divisor_zero;
                w_zero_req = start &&  w_divisor_zero;
            end
            c_calc: begin
                busy   = 1'b1;
                w_step = 1'b1;
            end
            c_fix: begin
                busy     = 1'b1;
                w_finish = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_q        <= '0;
            r_rem      <= '0;
            r_mag      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;

            if (w_accept) begin
                r_q      <= w_dvd_mag;
                r_mag    <= w_dvs_mag;
                r_rem    <= '0;
                r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_sign_r <= dividend[WIDTH-1];
                r_count  <= '0;
            end

            if (w_zero_req) begin
                r_done     <= 1'b1;
                r_div_zero <= 1'b1;
            end

            if (w_step) begin
                // Restoring step: keep the trial remainder only when it did not go negative.
                if (!w_trial[WIDTH]) begin
                    r_rem <= w_trial[WIDTH-1:0];
                end else begin
                    r_rem <= w_rem_shifted[WIDTH-1:0];
                end
                r_q     <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                r_count <= r_count + 1'b1;
            end

            if (w_finish) begin
                r_lo   <= r_sign_q ? (~r_q   + 1'b1) : r_q;
                r_hi   <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                r_done <= 1'b1;
            end
        end
    end

    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_signed_divider
//  Purpose  : Self-checking bench for signed_divider against a 64-bit
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_signed_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    signed_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Truncating signed division done at 64 bits so no operand pair overflows.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Launches one operation and waits (bounded) for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got_lo, output logic [31:0] got_hi,
                          output int lat, output int bc, output logic dz);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bc    = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bc++;
            tick();
            lat++;
        end
        got_lo = lo;
        got_hi = hi;
        dz     = div_zero;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: busy/done/dz=%b hi=%h lo=%h, need 000 0 0",
                     {busy, done, div_zero}, hi, lo);
        end
    endtask

    task automatic test_basic;
        logic [31:0] ql, rh;
        int lat, bc;
        logic dz;
        run_op(32'd7, 32'd2, ql, rh, lat, bc, dz);
        vectors++;
        if (ql !== 32'd3 || rh !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_7_2: lo=%h hi=%h, need 3 1", ql, rh);
        end
        vectors++;
        if (lat !== 33 || bc !== 33) begin
            miscompares++;
            $display("FAIL basic_latency: lat=%0d busy_cycles=%0d, need 33 33", lat, bc);
        end
        vectors++;
        if (busy !== 1'b0 || dz !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_flags: busy=%b dz=%b at done, need 0 0", busy, dz);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || lo !== 32'd3 || hi !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_hold: done=%b lo=%h hi=%h, need 0 3 1", done, lo, hi);
        end
    endtask

    task automatic test_signs;
        logic [31:0] a_t [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
        logic [31:0] b_t [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] q_t [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000003};
        logic [31:0] r_t [3] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
        logic [31:0] ql, rh;
        int lat, bc;
        logic dz;
        for (int i = 0; i < 3; i++) begin
            run_op(a_t[i], b_t[i], ql, rh, lat, bc, dz);
            vectors++;
            if (ql !== q_t[i] || rh !== r_t[i] || lat !== 33) begin
                miscompares++;
                $display("FAIL signs[%0d]: lo=%h hi=%h lat=%0d, need %h %h 33",
                         i, ql, rh, lat, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] ql, rh;
        int lat, bc;
        logic dz;
        run_op(32'd7, 32'd2, ql, rh, lat, bc, dz);
        tick();
        dividend = 32'h12345678;
        divisor  = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL divzero_flags: done=%b dz=%b busy=%b, need 1 1 0", done, div_zero, busy);
        end
        vectors++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            miscompares++;
            $display("FAIL divzero_hold: hi=%h lo=%h, need 1 3", hi, lo);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL divzero_pulse: done=%b dz=%b busy=%b, need 0 0 0", done, div_zero, busy);
        end
    endtask

    task automatic test_boundary;
        logic [31:0] a_t [3] = '{32'h80000000, 32'hFFFFFFFF, 32'd100};
        logic [31:0] b_t [3] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd7};
        logic [31:0] q_t [3] = '{32'h80000000, 32'h00000000, 32'd14};
        logic [31:0] r_t [3] = '{32'h00000000, 32'hFFFFFFFF, 32'd2};
        logic [31:0] ql, rh;
        int lat, bc;
        logic dz;
        for (int i = 0; i < 3; i++) begin
            run_op(a_t[i], b_t[i], ql, rh, lat, bc, dz);
            vectors++;
            if (ql !== q_t[i] || rh !== r_t[i] || dz !== 1'b0) begin
                miscompares++;
                $display("FAIL boundary[%0d]: lo=%h hi=%h dz=%b, need %h %h 0",
                         i, ql, rh, dz, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 9) begin
                dividend = 32'd100;
                divisor  = 32'd7;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        vectors++;
        if (lat !== 33 || lo !== 32'd3 || hi !== 32'd1) begin
            miscompares++;
            $display("FAIL ignored_start: lat=%0d lo=%h hi=%h, need 33 3 1", lat, lo, hi);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_restart: busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        dividend = 32'd9;
        divisor  = 32'd4;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_first: lat=%0d lo=%h hi=%h, need 33 e 2", lat, lo, hi);
        end
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b, need 1 0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 33 || lo !== 32'd2 || hi !== 32'd1) begin
            miscompares++;
            $display("FAIL b2b_second: lat=%0d lo=%h hi=%h, need 33 2 1", lat, lo, hi);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ql, rh;
        int lat, bc;
        logic dz;
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, need 0 0 0 0", busy, done, hi, lo);
        end
        run_op(32'd9, 32'd4, ql, rh, lat, bc, dz);
        vectors++;
        if (ql !== 32'd2 || rh !== 32'd1 || lat !== 33) begin
            miscompares++;
            $display("FAIL reset_mid_after: lo=%h hi=%h lat=%0d, need 2 1 33", ql, rh, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, eq, er, ql, rh;
        int lat, bc;
        logic dz;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = $urandom_range(1, 300);
            if (i % 5 == 1) b = -$urandom_range(1, 300);
            if (b == 32'd0) b = 32'd1;
            model(a, b, eq, er);
            run_op(a, b, ql, rh, lat, bc, dz);
            vectors++;
            if (ql !== eq || rh !== er || lat !== 33 || dz !== 1'b0) begin
                miscompares++;
                $display("FAIL random %h/%h: lo=%h hi=%h lat=%0d dz=%b, need %h %h 33 0",
                         a, b, ql, rh, lat, dz, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_boundary();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
